// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared multi-cycle ALU: arbitrates, drives the ALU
// operand registers, waits ALU_LAT+1 cycles, returns the result. Macro ALU_ARB_ROUND_ROBIN_EN selects round-robin.
module alu_arbiter #(
    parameter int ALU_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [2:0] req0_op,
    input  logic [1:0] req0_a,
    input  logic [1:0] req0_b,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [2:0] req1_op,
    input  logic [1:0] req1_a,
    input  logic [1:0] req1_b,
    output logic       req1_ready,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic [3:0] rsp_data,
    output logic       rsp_err,
    input  logic       rsp_ready,
    output logic [1:0] alu_a,
    output logic [1:0] alu_b,
    output logic [2:0] alu_s,
    input  logic [3:0] alu_f,
    output logic [1:0] dbg_state
);

    // Handshake: a request transfers on a rising edge where reqN_valid and reqN_ready
    // are both high; a response transfers on an edge where rsp_valid and rsp_ready are high.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [2:0] LAT_INIT   = 3'(ALU_LAT);
    localparam logic [2:0] OP_ILLEGAL = 3'd7;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] cnt;
    logic       grant1;
    logic       accept;
    logic [2:0] sel_op;
    logic [1:0] sel_a;
    logic [1:0] sel_b;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    // ptr names the requester favoured when both are valid
    logic ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (accept) begin
            ptr <= ~grant1;
        end
    end

    assign grant1 = req1_valid & (~req0_valid | ptr);
`else
    assign grant1 = req1_valid & ~req0_valid;
`endif

    assign req0_ready = (state == S_IDLE) & ~rst & req0_valid & ~grant1;
    assign req1_ready = (state == S_IDLE) & ~rst & grant1;
    assign accept     = req0_ready | req1_ready;

    assign sel_op = grant1 ? req1_op : req0_op;
    assign sel_a  = grant1 ? req1_a  : req0_a;
    assign sel_b  = grant1 ? req1_b  : req0_b;

    assign rsp_valid = (state == S_RESP);
    assign dbg_state = state;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = (sel_op == OP_ILLEGAL) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == 3'd0) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ALU operand registers change only on a legal accept, so they stay stable until the next one
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_id   <= 1'b0;
            rsp_data <= 4'd0;
            rsp_err  <= 1'b0;
            alu_a    <= 2'd0;
            alu_b    <= 2'd0;
            alu_s    <= 3'd0;
            cnt      <= 3'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        rsp_id <= grant1;
                        if (sel_op == OP_ILLEGAL) begin
                            rsp_data <= 4'd0;
                            rsp_err  <= 1'b1;
                        end else begin
                            alu_a <= sel_a;
                            alu_b <= sel_b;
                            alu_s <= sel_op;
                            cnt   <= LAT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 3'd0) begin
                        rsp_data <= alu_f;
                        rsp_err  <= 1'b0;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: instance a at ALU_LAT=1, instance b at ALU_LAT=3,
// each fed by a small external ALU model with matching pipeline latency.
module tb_alu_arbiter;

    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       req0_valid, req1_valid, req0_ready, req1_ready;
    logic [2:0] req0_op, req1_op;
    logic [1:0] req0_a, req0_b, req1_a, req1_b;
    logic       rsp_valid, rsp_id, rsp_err, rsp_ready;
    logic [3:0] rsp_data, alu_f;
    logic [1:0] alu_a, alu_b, dbg_state;
    logic [2:0] alu_s;

    logic       b_req0_valid, b_req1_valid, b_req0_ready, b_req1_ready;
    logic [2:0] b_req0_op, b_req1_op;
    logic [1:0] b_req0_a, b_req0_b, b_req1_a, b_req1_b;
    logic       b_rsp_valid, b_rsp_id, b_rsp_err, b_rsp_ready;
    logic [3:0] b_rsp_data, b_alu_f;
    logic [1:0] b_alu_a, b_alu_b, b_dbg_state;
    logic [2:0] b_alu_s;

    logic [3:0] pipe_a;
    logic [3:0] pipe_b [0:2];

    int n_total = 0;
    int n_bad   = 0;
    logic [4:0] exp_q[$];

    alu_arbiter #(.ALU_LAT(LAT_A)) u_dut_a (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_f(alu_f), .dbg_state(dbg_state)
    );

    alu_arbiter #(.ALU_LAT(LAT_B)) u_dut_b (
        .clk(clk), .rst(rst),
        .req0_valid(b_req0_valid), .req0_op(b_req0_op), .req0_a(b_req0_a), .req0_b(b_req0_b), .req0_ready(b_req0_ready),
        .req1_valid(b_req1_valid), .req1_op(b_req1_op), .req1_a(b_req1_a), .req1_b(b_req1_b), .req1_ready(b_req1_ready),
        .rsp_valid(b_rsp_valid), .rsp_id(b_rsp_id), .rsp_data(b_rsp_data), .rsp_err(b_rsp_err), .rsp_ready(b_rsp_ready),
        .alu_a(b_alu_a), .alu_b(b_alu_b), .alu_s(b_alu_s), .alu_f(b_alu_f), .dbg_state(b_dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    // external ALU: 2-bit ops zero-extended, ADD keeps carry, MUL is 4-bit
    function automatic logic [3:0] alu_fn(input logic [1:0] a, input logic [1:0] b, input logic [2:0] s);
        logic [1:0] d;
        d = a - b;
        case (s)
            3'd0:    return {2'b00, a & b};
            3'd1:    return {2'b00, a ^ b};
            3'd2:    return {2'b00, a | b};
            3'd3:    return {2'b00, ~(a & b)};
            3'd4:    return {2'b00, a} * {2'b00, b};
            3'd5:    return {2'b00, a} + {2'b00, b};
            3'd6:    return {2'b00, d};
            default: return 4'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        pipe_a    <= alu_fn(alu_a, alu_b, alu_s);
        pipe_b[0] <= alu_fn(b_alu_a, b_alu_b, b_alu_s);
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign alu_f   = pipe_a;
    assign b_alu_f = pipe_b[LAT_B-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // counts rising edges after the accept edge until rsp_valid is seen
    task automatic wait_rsp(input string tag, output int edges);
        edges = 0;
        while (!rsp_valid && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        if (!rsp_valid) chk({tag, "_timeout"}, 0, 1);
    endtask

    // driver: one full transaction on instance a
    task automatic run_one(input string tag, input logic id, input logic [2:0] op,
                           input logic [1:0] a, input logic [1:0] b,
                           input int exp_edges, input logic [3:0] exp_data, input logic exp_err);
        int edges;
        @(negedge clk);
        if (id) begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end
        #1;
        chk({tag, "_ready"}, {req1_ready, req0_ready}, id ? 2'b10 : 2'b01);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_rsp(tag, edges);
        chk({tag, "_lat"}, edges, exp_edges);
        chk({tag, "_id"}, rsp_id, id);
        chk({tag, "_data"}, rsp_data, exp_data);
        chk({tag, "_err"}, rsp_err, exp_err);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_drop"}, rsp_valid, 0);
    endtask

    initial begin
        int edges;
        int grants;
        int cyc;
        logic seen;
        logic [4:0] exp_item;
        logic [3:0] grant_order;

        req0_valid = 1'b1; req0_op = 3'd0; req0_a = 2'd0; req0_b = 2'd0;
        req1_valid = 1'b1; req1_op = 3'd0; req1_a = 2'd0; req1_b = 2'd0;
        rsp_ready = 1'b0;
        b_req0_valid = 1'b0; b_req0_op = 3'd0; b_req0_a = 2'd0; b_req0_b = 2'd0;
        b_req1_valid = 1'b0; b_req1_op = 3'd0; b_req1_a = 2'd0; b_req1_b = 2'd0;
        b_rsp_ready = 1'b0;

        // reset: readys masked while rst is high, then all outputs cleared
        repeat (2) @(negedge clk);
        chk("rst_ready", {req1_ready, req0_ready}, 2'b00);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_rsp", {rsp_valid, rsp_id, rsp_err, rsp_data}, 7'd0);
        chk("rst_alu", {alu_a, alu_b, alu_s}, 7'd0);
        chk("rst_b", {b_rsp_valid, b_rsp_data, b_alu_a, b_alu_b, b_alu_s}, 12'd0);

        // req0 ADD 3+2
        run_one("add", 1'b0, 3'd5, 2'd3, 2'd2, 2, 4'b0101, 1'b0);
        chk("add_alu", {alu_a, alu_b, alu_s}, {2'd3, 2'd2, 3'd5});

        // req1 illegal op: immediate error response, ALU registers untouched
        run_one("ill", 1'b1, 3'd7, 2'd1, 2'd1, 0, 4'd0, 1'b1);
        chk("ill_alu", {alu_a, alu_b, alu_s}, {2'd3, 2'd2, 3'd5});

        // both valid continuously, consumer always ready
`ifdef ALU_ARB_ROUND_ROBIN_EN
        grant_order = 4'b1010;
`else
        grant_order = 4'b0000;
`endif
        @(negedge clk);
        req0_valid = 1'b1; req0_op = 3'd4; req0_a = 2'd3; req0_b = 2'd3;
        req1_valid = 1'b1; req1_op = 3'd6; req1_a = 2'd1; req1_b = 2'd2;
        rsp_ready = 1'b1;
        grants = 0;
        cyc = 0;
        while (cyc < 60 && !(grants == 4 && exp_q.size() == 0)) begin
            #1;
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("both_unexpected_rsp", 1, 0);
                end else begin
                    exp_item = exp_q.pop_front();
                    chk("both_rsp", {rsp_id, rsp_data}, exp_item);
                end
            end
            if (grants == 4) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end else if (req0_ready || req1_ready) begin
                chk("both_grant", req1_ready, grant_order[grants]);
                exp_q.push_back(req1_ready ? {1'b1, 4'b0011} : {1'b0, 4'd9});
                grants++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("both_done", {grants == 4, exp_q.size() == 0}, 2'b11);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b0;

        // response back-pressure with a pending req0 held
        @(negedge clk);
        req1_valid = 1'b1; req1_op = 3'd1; req1_a = 2'd2; req1_b = 2'd3;
        #1;
        chk("hold_ready1", req1_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_op = 3'd2; req0_a = 2'd1; req0_b = 2'd2;
        wait_rsp("hold", edges);
        chk("hold_lat", edges, 2);
        for (int i = 0; i < 5; i++) begin
            chk("hold_rsp", {rsp_valid, rsp_id, rsp_err, rsp_data}, {3'b110, 4'b0001});
            chk("hold_readys", {req1_ready, req0_ready}, 2'b00);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("hold_grant", {rsp_valid, req0_ready}, 2'b01);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        wait_rsp("held", edges);
        chk("held_rsp", {edges[3:0], rsp_id, rsp_err, rsp_data}, {4'd2, 2'b00, 4'b0011});
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // reset pulse during WAIT abandons the transaction
        req0_valid = 1'b1; req0_op = 3'd5; req0_a = 2'd1; req0_b = 2'd1;
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_op = 3'd0; req1_a = 2'd3; req1_b = 2'd2;
        rst = 1'b1;
        @(negedge clk);
        chk("wrst_ready", {req1_ready, req0_ready}, 2'b00);
        rst = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk("wrst_rsp", {rsp_valid, rsp_id, rsp_err, rsp_data}, 7'd0);
        chk("wrst_alu", {alu_a, alu_b, alu_s}, 7'd0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen = seen | rsp_valid;
        end
        chk("wrst_no_rsp", seen, 0);
        run_one("after_rst", 1'b1, 3'd0, 2'd3, 2'd2, 2, 4'b0010, 1'b0);

        // ALU_LAT=3 instance: NAND 1,1
        @(negedge clk);
        b_req0_valid = 1'b1; b_req0_op = 3'd3; b_req0_a = 2'd1; b_req0_b = 2'd1;
        #1;
        chk("lat3_ready", b_req0_ready, 1);
        @(posedge clk);
        @(negedge clk);
        b_req0_valid = 1'b0;
        edges = 0;
        while (!b_rsp_valid && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        chk("lat3_lat", edges, 4);
        chk("lat3_rsp", {b_rsp_valid, b_rsp_id, b_rsp_err, b_rsp_data}, {3'b100, 4'b0010});
        b_rsp_ready = 1'b1;
        @(negedge clk);
        b_rsp_ready = 1'b0;
        chk("lat3_drop", b_rsp_valid, 0);

        // final report
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: ALU_LAT, default 1, cycles from the alu_a/alu_b/alu_s update to a valid alu_f (1..7).
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 req0_valid / req1_valid  input  1  requester N has an operation pending.
REQ-005 req0_op / req1_op  input  3  opcode: 0 AND, 1 XOR, 2 OR, 3 NAND, 4 MUL, 5 ADD, 6 SUB, 7 illegal.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  2  operands.
REQ-007 req0_ready / req1_ready  output  1  grant; transfer when valid & ready on same edge.
REQ-008 rsp_valid  output  1  response available.
REQ-009 rsp_id  output  1  index of requester owning the response.
REQ-010 rsp_data  output  4  captured ALU result.
REQ-011 rsp_err  output  1  illegal opcode flag.
REQ-012 rsp_ready  input  1  consumer accepts response.
REQ-013 alu_a, alu_b  output  2  registered operands to the shared ALU.
REQ-014 alu_s  output  3  registered opcode to the shared ALU.
REQ-015 alu_f  input  4  ALU result.

Function
REQ-016 FSM states IDLE, WAIT, RESP; exactly one transaction in flight.
REQ-017 reqN_ready SHALL be high only in IDLE, only for the granted requester, combinationally from reqN_valid and the arbitration pointer; at most one ready high per cycle.
REQ-018 IDLE, accept edge, legal op: load alu_a/alu_b/alu_s and the owner id, load the wait counter with ALU_LAT, go to WAIT.
REQ-019 IDLE, accept edge, op 7: leave alu_* unchanged, go directly to RESP next cycle with rsp_err=1, rsp_data=0.
REQ-020 WAIT lasts ALU_LAT+1 cycles; on its final edge, capture alu_f into rsp_data, rsp_err=0, go to RESP; rsp_valid is therefore high ALU_LAT+1 cycles after the accept edge.
REQ-021 alu_a/alu_b/alu_s SHALL hold stable from the accept edge until the next accept.
REQ-022 RESP: rsp_valid=1; rsp_id/rsp_data/rsp_err stable while rsp_ready=0; on the edge with rsp_ready=1 go to IDLE and drop rsp_valid.
REQ-023 No bypass: a new accept occurs no earlier than the cycle after the response handshake; minimum period ALU_LAT+3 cycles for legal ops.
REQ-024 Requests in WAIT/RESP see ready=0 and SHALL be held by the requester; a held request is not lost.
REQ-025 Arbitration with one valid requester: grant it regardless of the pointer.

Reset
REQ-026 rst SHALL force state IDLE, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, alu_a=0, alu_b=0, alu_s=0, counter=0, pointer favouring requester 0.
REQ-027 rst asserted in WAIT or RESP SHALL abandon the transaction; no response is produced for it.
REQ-028 reqN_ready SHALL be 0 during any cycle with rst=1.

Configuration
REQ-029 Macro ALU_ARB_ROUND_ROBIN_EN defined: both valid, grant the requester not granted last; pointer updates on every accept (including op 7).
REQ-030 Macro undefined: fixed priority, requester 0 always wins when both valid; pointer logic absent.

Verification
REQ-031 Reset, then req0 ADD a=3 b=2 -> req0_ready same cycle; rsp_valid 2 cycles after accept (ALU_LAT=1), rsp_id=0, rsp_data=4'b0101, rsp_err=0.
REQ-032 Both valid continuously (req0 MUL 3x3, req1 SUB 1-2), rsp_ready=1 -> with _EN grant order 0,1,0,1 and rsp_data 9/4'b0011 alternating; without _EN only req0 granted.
REQ-033 req1 op 7 -> rsp_valid next cycle after accept, rsp_err=1, rsp_data=0, alu_s unchanged.
REQ-034 rsp_ready held 0 for 5 cycles in RESP -> rsp fields stable, both readys 0, pending req0 held; grant occurs cycle after rsp_ready=1 edge.
REQ-035 rst pulsed one cycle during WAIT -> no rsp_valid for that transaction, all outputs zero, next request served normally.
REQ-036 ALU_LAT=3, req0 NAND a=1 b=1 -> rsp_valid exactly 4 cycles after accept, rsp_data=4'b0010.
